// File: rtl/divider_if.sv
// Operand/result handshake bundle for the iterative integer divider.
interface divider_if #(
  parameter int unsigned width = 32
) ();
  logic [width-1:0] divident;
  logic [width-1:0] divisor;
  logic             return_remainder_or_queotient;
  logic             start_flag;
  logic             signed_i;
  logic             busy_o;
  logic             valid_o;
  logic             error_o;
  logic [width-1:0] result_o;

  modport master (
    output divident, divisor, return_remainder_or_queotient, start_flag, signed_i,
    input  busy_o, valid_o, error_o, result_o
  );

  modport slave (
    input  divident, divisor, return_remainder_or_queotient, start_flag, signed_i,
    output busy_o, valid_o, error_o, result_o
  );
endinterface

// File: rtl/divider.sv
// Radix-2 restoring divider: one quotient bit per clock, RISC-V DIV/DIVU/REM/REMU results.
module divider #(
  parameter int unsigned width = 32
) (
  input  logic     clk,
  input  logic     rst_i,
  divider_if.slave bus
);
  localparam int unsigned CW = $clog2(width + 1);

  localparam logic [1:0] IDLE = 2'd0;
  localparam logic [1:0] DIV  = 2'd1;
  localparam logic [1:0] DONE = 2'd2;

  logic [1:0]       state_q, state_d;
  logic [width-1:0] rem_q, rem_d, quo_q, quo_d;
  logic [width-1:0] dvs_q, dvs_d, dvd_q, dvd_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             qneg_q, qneg_d, rneg_q, rneg_d;
  logic             sel_q, sel_d, zero_q, zero_d;
  logic             busy_q, busy_d, valid_q, valid_d, error_q, error_d;
  logic [width-1:0] result_q, result_d;

  logic             dvd_neg, dvs_neg;
  logic [width-1:0] dvd_abs, dvs_abs, quo_fix, rem_fix;
  logic [width:0]   shifted, diff;

  // Next-state, datapath step and output selection
  always_comb begin
    state_d  = state_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    dvs_d    = dvs_q;
    dvd_d    = dvd_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    sel_d    = sel_q;
    zero_d   = zero_q;
    busy_d   = busy_q;
    valid_d  = 1'b0;
    error_d  = error_q;
    result_d = result_q;

    dvd_neg = bus.signed_i & bus.divident[width-1];
    dvs_neg = bus.signed_i & bus.divisor[width-1];
    dvd_abs = dvd_neg ? (~bus.divident + width'(1)) : bus.divident;
    dvs_abs = dvs_neg ? (~bus.divisor + width'(1)) : bus.divisor;

    shifted = {rem_q, quo_q[width-1]};
    diff    = shifted - {1'b0, dvs_q};
    quo_fix = qneg_q ? (~quo_q + width'(1)) : quo_q;
    rem_fix = rneg_q ? (~rem_q + width'(1)) : rem_q;

    case (state_q)
      IDLE: begin
        if (bus.start_flag) begin
          quo_d   = dvd_abs;
          rem_d   = '0;
          dvs_d   = dvs_abs;
          dvd_d   = bus.divident;
          qneg_d  = dvd_neg ^ dvs_neg;
          rneg_d  = dvd_neg;
          sel_d   = bus.return_remainder_or_queotient;
          zero_d  = (bus.divisor == '0);
          cnt_d   = CW'(width);
          busy_d  = 1'b1;
          state_d = DIV;
        end
      end
      DIV: begin
        // Restore by keeping the unsubtracted value when the trial goes negative
        if (!diff[width]) begin
          rem_d = diff[width-1:0];
          quo_d = {quo_q[width-2:0], 1'b1};
        end else begin
          rem_d = shifted[width-1:0];
          quo_d = {quo_q[width-2:0], 1'b0};
        end
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = DONE;
        end
      end
      DONE: begin
        // Zero divisor bypasses the sign fixup: all-ones quotient, raw dividend remainder
        if (zero_q) begin
          result_d = sel_q ? dvd_q : '1;
        end else begin
          result_d = sel_q ? rem_fix : quo_fix;
        end
        error_d = zero_q;
        valid_d = 1'b1;
        busy_d  = 1'b0;
        state_d = IDLE;
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // State and datapath registers
  always_ff @(posedge clk or negedge rst_i) begin
    if (!rst_i) begin
      state_q  <= IDLE;
      rem_q    <= '0;
      quo_q    <= '0;
      dvs_q    <= '0;
      dvd_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      sel_q    <= 1'b0;
      zero_q   <= 1'b0;
      busy_q   <= 1'b0;
      valid_q  <= 1'b0;
      error_q  <= 1'b0;
      result_q <= '0;
    end else begin
      state_q  <= state_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      dvs_q    <= dvs_d;
      dvd_q    <= dvd_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      sel_q    <= sel_d;
      zero_q   <= zero_d;
      busy_q   <= busy_d;
      valid_q  <= valid_d;
      error_q  <= error_d;
      result_q <= result_d;
    end
  end

  assign bus.busy_o   = busy_q;
  assign bus.valid_o  = valid_q;
  assign bus.error_o  = error_q;
  assign bus.result_o = result_q;
endmodule

// File: tb/tb_divider.sv
// Self-checking bench for divider: directed spec vectors, protocol cases and random ops vs. an arithmetic model.
module tb_divider;
  localparam int unsigned W = 32;
  localparam logic [31:0] MIN = 32'h8000_0000;

  logic clk = 1'b0;
  logic rst_i = 1'b0;
  int   tests = 0;
  int   fails = 0;

  divider_if #(.width(W)) bus ();

  divider #(.width(W)) dut (
    .clk   (clk),
    .rst_i (rst_i),
    .bus   (bus.slave)
  );

  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    if (obs !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Reference: RISC-V division rules with plain integer arithmetic
  function automatic void ref_div(input logic [31:0] a, input logic [31:0] b, input logic rs,
                                  input logic sg, output logic [31:0] r, output logic e);
    int sa, sb;
    sa = a;
    sb = b;
    e = 1'b0;
    if (b == 32'd0) begin
      e = 1'b1;
      r = rs ? a : 32'hFFFF_FFFF;
    end else if (sg) begin
      if (a == MIN && b == 32'hFFFF_FFFF) r = rs ? 32'd0 : MIN;
      else r = rs ? 32'(sa % sb) : 32'(sa / sb);
    end else begin
      r = rs ? (a % b) : (a / b);
    end
  endfunction

  task automatic scramble_inputs();
    bus.divident = $urandom;
    bus.divisor  = $urandom;
    bus.return_remainder_or_queotient = 1'($urandom_range(0, 1));
    bus.signed_i = 1'($urandom_range(0, 1));
  endtask

  // One operation; start sampled at the end of cycle 0, valid expected in cycle 34
  task automatic do_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                       input logic rs, input logic sg, input logic [31:0] exp_r,
                       input logic exp_e, input bit poke);
    int cyc;
    bit busy_ok;
    @(negedge clk);
    bus.divident = a;
    bus.divisor  = b;
    bus.return_remainder_or_queotient = rs;
    bus.signed_i = sg;
    bus.start_flag = 1'b1;
    @(posedge clk); #1;
    cyc = 1;
    bus.start_flag = 1'b0;
    scramble_inputs();
    busy_ok = 1'b1;
    while (!bus.valid_o && cyc < 50) begin
      if (!bus.busy_o) busy_ok = 1'b0;
      bus.start_flag = poke && (cyc == 10);
      @(posedge clk); #1;
      cyc++;
    end
    bus.start_flag = 1'b0;
    check_eq({tag, " valid_seen"}, 32'(bus.valid_o), 32'd1);
    check_eq({tag, " latency"}, 32'(cyc), 32'd34);
    check_eq({tag, " busy_during"}, 32'(busy_ok), 32'd1);
    check_eq({tag, " busy_at_valid"}, 32'(bus.busy_o), 32'd0);
    check_eq({tag, " result"}, bus.result_o, exp_r);
    check_eq({tag, " error"}, 32'(bus.error_o), 32'(exp_e));
    @(posedge clk); #1;
    check_eq({tag, " valid_pulse"}, 32'(bus.valid_o), 32'd0);
    check_eq({tag, " result_hold"}, bus.result_o, exp_r);
    check_eq({tag, " error_hold"}, 32'(bus.error_o), 32'(exp_e));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] a, b, er;
    logic rs, sg, ee;
    int valids;

    bus.start_flag = 1'b0;
    scramble_inputs();
    repeat (2) @(posedge clk);
    #1;
    check_eq("reset busy", 32'(bus.busy_o), 32'd0);
    check_eq("reset valid", 32'(bus.valid_o), 32'd0);
    check_eq("reset error", 32'(bus.error_o), 32'd0);
    check_eq("reset result", bus.result_o, 32'd0);
    @(negedge clk);
    rst_i = 1'b1;

    do_op("u75/15",     32'd75,    32'd15,    1'b0, 1'b0, 32'd5,          1'b0, 1'b0);
    do_op("u75%15",     32'd75,    32'd15,    1'b1, 1'b0, 32'd0,          1'b0, 1'b0);
    do_op("s75/15",     32'd75,    32'd15,    1'b0, 1'b1, 32'd5,          1'b0, 1'b0);
    do_op("s75%-13",    32'd75,    -32'd13,   1'b1, 1'b1, 32'd10,         1'b0, 1'b0);
    do_op("s5%-13",     32'd5,     -32'd13,   1'b1, 1'b1, 32'd5,          1'b0, 1'b0);
    do_op("s75%-15",    32'd75,    -32'd15,   1'b1, 1'b1, 32'd0,          1'b0, 1'b0);
    do_op("s-75%13",    -32'd75,   32'd13,    1'b1, 1'b1, 32'hFFFF_FFF6,  1'b0, 1'b0);
    do_op("s-5%13",     -32'd5,    32'd13,    1'b1, 1'b1, 32'hFFFF_FFFB,  1'b0, 1'b0);
    do_op("s-75/13",    -32'd75,   32'd13,    1'b0, 1'b1, 32'hFFFF_FFFB,  1'b0, 1'b0);
    do_op("s-1050/-300", -32'd1050, -32'd300, 1'b0, 1'b1, 32'd3,          1'b0, 1'b0);
    do_op("s-1050%-300", -32'd1050, -32'd300, 1'b1, 1'b1, 32'hFFFF_FF6A,  1'b0, 1'b0);
    do_op("u75/0",      32'd75,    32'd0,     1'b0, 1'b0, 32'hFFFF_FFFF,  1'b1, 1'b0);
    do_op("s-75/0",     -32'd75,   32'd0,     1'b0, 1'b1, 32'hFFFF_FFFF,  1'b1, 1'b0);
    do_op("s-75%0",     -32'd75,   32'd0,     1'b1, 1'b1, -32'd75,        1'b1, 1'b0);
    do_op("smin/-1",    MIN,       -32'd1,    1'b0, 1'b1, MIN,            1'b0, 1'b0);
    do_op("smin%-1",    MIN,       -32'd1,    1'b1, 1'b1, 32'd0,          1'b0, 1'b0);
    do_op("umax/1",     32'hFFFF_FFFF, 32'd1, 1'b0, 1'b0, 32'hFFFF_FFFF,  1'b0, 1'b0);
    do_op("ignore_start", 32'd1000, 32'd7,    1'b0, 1'b0, 32'd142,        1'b0, 1'b1);
    do_op("u75%0",      32'd75,    32'd0,     1'b1, 1'b0, 32'd75,         1'b1, 1'b0);

    // Abort mid-divide: outputs clear asynchronously, no completion follows
    @(negedge clk);
    bus.divident = 32'd999;
    bus.divisor  = 32'd3;
    bus.return_remainder_or_queotient = 1'b0;
    bus.signed_i = 1'b0;
    bus.start_flag = 1'b1;
    @(posedge clk); #1;
    bus.start_flag = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    check_eq("abort busy_before", 32'(bus.busy_o), 32'd1);
    rst_i = 1'b0;
    #1;
    check_eq("abort busy", 32'(bus.busy_o), 32'd0);
    check_eq("abort valid", 32'(bus.valid_o), 32'd0);
    check_eq("abort error", 32'(bus.error_o), 32'd0);
    check_eq("abort result", bus.result_o, 32'd0);
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst_i = 1'b1;
    valids = 0;
    repeat (45) begin
      @(posedge clk); #1;
      if (bus.valid_o || bus.busy_o) valids++;
    end
    check_eq("abort no_completion", 32'(valids), 32'd0);

    for (int i = 0; i < 40; i++) begin
      a  = $urandom;
      rs = 1'($urandom_range(0, 1));
      sg = 1'($urandom_range(0, 1));
      case ($urandom_range(0, 4))
        0: b = $urandom;
        1: b = 32'($urandom_range(1, 20));
        2: b = -32'($urandom_range(1, 20));
        3: b = 32'd0;
        default: begin a = MIN; b = 32'hFFFF_FFFF; end
      endcase
      if ($urandom_range(0, 3) == 0) a = 32'($urandom_range(0, 100));
      ref_div(a, b, rs, sg, er, ee);
      do_op($sformatf("rnd%0d", i), a, b, rs, sg, er, ee, 1'b0);
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
